// File: rtl/gray_seq_if.sv
// Control/config and code-output bundle for gray_seq_ctrl.
// master: configuration/control side plus consumer ready; slave: the sequencer.
interface gray_seq_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] cfg_first;
  logic [WIDTH-1:0] cfg_last;
  logic             cfg_dir;
  logic             cfg_loop;
  logic [DIV_W-1:0] cfg_div;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic [WIDTH-1:0] out_gray;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             err;

  modport master (
    output start, abort, cfg_first, cfg_last, cfg_dir, cfg_loop, cfg_div, out_ready,
    input  out_valid, out_bin, out_gray, busy, done, wrap, err
  );

  modport slave (
    input  start, abort, cfg_first, cfg_last, cfg_dir, cfg_loop, cfg_div, out_ready,
    output out_valid, out_bin, out_gray, busy, done, wrap, err
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Gray-code sequencer: walks a cyclic binary range up or down, presenting each
// code with its Gray equivalent on a valid/ready port, with optional looping and
// a programmable idle gap after each transfer.
// Optional macro GRAY_CHECK_EN adds a sticky Gray-adjacency checker on err.
module gray_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 4
) (
  input logic      clk,
  input logic      rst_n,
  gray_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] bin_q, bin_n;
  logic [WIDTH-1:0] gray_q;
  logic [DIV_W-1:0] gap_q, gap_n;
  logic [WIDTH-1:0] first_q, last_q;
  logic             dir_q, loop_q;
  logic [DIV_W-1:0] div_q;
  logic             valid_q, busy_q, done_q, wrap_q;
  logic             wrap_n;
  logic             cfg_load;
  logic             xfer;

  // valid_q is high exactly while in PRESENT, so it doubles as the transfer qualifier
  assign xfer = valid_q & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Next-state, next code, gap counter and wrap decode; abort overrides everything
  always_comb begin
    state_n  = state_q;
    bin_n    = bin_q;
    gap_n    = gap_q;
    wrap_n   = 1'b0;
    cfg_load = 1'b0;
    if (bus.abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cfg_load = 1'b1;
            bin_n    = bus.cfg_first;
            state_n  = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (xfer) begin
            if ((bin_q == last_q) && !loop_q) begin
              state_n = S_DONE;
            end else begin
              if (bin_q == last_q) begin
                bin_n  = first_q;
                wrap_n = 1'b1;
              end else if (dir_q) begin
                bin_n = bin_q - WIDTH'(1);
              end else begin
                bin_n = bin_q + WIDTH'(1);
              end
              if (div_q == '0) begin
                state_n = S_PRESENT;
              end else begin
                state_n = S_GAP;
                gap_n   = div_q;
              end
            end
          end
        end
        S_GAP: begin
          gap_n = gap_q - DIV_W'(1);
          if (gap_q <= DIV_W'(1)) state_n = S_PRESENT;
        end
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Code, gap counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      gray_q  <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_n;
      gray_q  <= bin_n ^ (bin_n >> 1);
      gap_q   <= gap_n;
      valid_q <= (state_n == S_PRESENT);
      busy_q  <= (state_n == S_PRESENT) || (state_n == S_GAP);
      done_q  <= (state_n == S_DONE);
      wrap_q  <= wrap_n;
    end
  end

  // Configuration snapshot taken on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
      last_q  <= '0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
      div_q   <= '0;
    end else if (cfg_load) begin
      first_q <= bus.cfg_first;
      last_q  <= bus.cfg_last;
      dir_q   <= bus.cfg_dir;
      loop_q  <= bus.cfg_loop;
      div_q   <= bus.cfg_div;
    end
  end

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             armed_q;
  logic             err_q;

  // Sticky adjacency check; first transfer of a pass and after a loop reload is exempt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (cfg_load) begin
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (xfer) begin
      if (armed_q && ($countones(prev_q ^ gray_q) != 1)) err_q <= 1'b1;
      prev_q  <= gray_q;
      armed_q <= !((bin_q == last_q) && loop_q);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.out_valid = valid_q;
  assign bus.out_bin   = bin_q;
  assign bus.out_gray  = gray_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: directed and randomized runs checked
// against a transfer-level reference built from the range/step/gap rules.
module tb_gray_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  gray_seq_if #(.WIDTH(4), .DIV_W(4)) bus ();

  gray_seq_ctrl #(.WIDTH(4), .DIV_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray_of(input logic [3:0] b);
    logic [3:0] g;
    for (int i = 0; i < 4; i++) g[i] = (i == 3) ? b[3] : (b[i] ^ b[i+1]);
    return g;
  endfunction

  // Number of codes in one pass of the cyclic range
  function automatic int seq_len(input logic [3:0] first, input logic [3:0] last, input bit dir);
    int d;
    d = dir ? int'(first) - int'(last) : int'(last) - int'(first);
    return ((d % 16 + 16) % 16) + 1;
  endfunction

  function automatic logic [3:0] code_at(input logic [3:0] first, input bit dir, input int i);
    int v;
    v = dir ? int'(first) - i : int'(first) + i;
    v = ((v % 16) + 16) % 16;
    return 4'(v);
  endfunction

  // Wait out the gap, check the presented code, stall, transfer, check aftermath
  task automatic transfer(input logic [3:0] exp_bin, input int exp_gap, input int stall,
                          input bit is_last, input bit loop);
    int gap_seen;
    gap_seen = 0;
    while (bus.out_valid !== 1'b1 && gap_seen < 40) begin
      check("busy_in_gap", 32'(bus.busy), 32'd1);
      bus.out_ready = 1'($urandom_range(0, 1));
      gap_seen++;
      tick();
    end
    check("gap_len", 32'(gap_seen), 32'(exp_gap));
    check("bin", 32'(bus.out_bin), 32'(exp_bin));
    check("gray", 32'(bus.out_gray), 32'(gray_of(exp_bin)));
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      bus.start     = 1'($urandom_range(0, 1));
      bus.cfg_first = 4'($urandom);
      bus.cfg_div   = 4'($urandom);
      tick();
      bus.start = 1'b0;
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_bin", 32'(bus.out_bin), 32'(exp_bin));
      check("stall_gray", 32'(bus.out_gray), 32'(gray_of(exp_bin)));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("wrap", 32'(bus.wrap), 32'(is_last && loop));
    check("err", 32'(bus.err), 32'd0);
    if (is_last && !loop) begin
      check("done_pulse", 32'(bus.done), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd0);
      check("done_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("done_end", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_valid", 32'(bus.out_valid), 32'd0);
    end else begin
      check("no_done", 32'(bus.done), 32'd0);
    end
  endtask

  task automatic abort_now();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      check("post_abort_valid", 32'(bus.out_valid), 32'd0);
      check("post_abort_done", 32'(bus.done), 32'd0);
    end
    bus.out_ready = 1'b0;
  endtask

  // One run; loop runs end with an abort after n_xfers transfers
  task automatic run(input logic [3:0] first, input logic [3:0] last, input bit dir,
                     input bit loop, input logic [3:0] div, input int n_xfers,
                     input int stall_at, input int stall_len);
    int len;
    int k;
    int st;
    logic [3:0] code;
    bus.cfg_first = first;
    bus.cfg_last  = last;
    bus.cfg_dir   = dir;
    bus.cfg_loop  = loop;
    bus.cfg_div   = div;
    bus.start     = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.cfg_last = 4'($urandom);
    bus.cfg_dir  = 1'($urandom_range(0, 1));
    bus.cfg_loop = 1'($urandom_range(0, 1));
    check("start_valid", 32'(bus.out_valid), 32'd1);
    check("start_busy", 32'(bus.busy), 32'd1);
    len = seq_len(first, last, dir);
    for (int i = 0; i < n_xfers; i++) begin
      k    = i % len;
      code = code_at(first, dir, k);
      st   = (int'(code) == stall_at) ? stall_len : int'($urandom_range(0, 2));
      transfer(code, (i == 0) ? 0 : int'(div), st, (k == len - 1), loop);
    end
    if (loop) abort_now();
  endtask

  initial begin
    logic [3:0] f, l;
    bit d;
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_first = '0;
    bus.cfg_last  = '0;
    bus.cfg_dir   = 1'b0;
    bus.cfg_loop  = 1'b0;
    bus.cfg_div   = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_bin", 32'(bus.out_bin), 32'd0);
    check("rst_gray", 32'(bus.out_gray), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full up count, stall 3 cycles at bin 5
    run(4'd0, 4'd15, 1'b0, 1'b0, 4'd0, 16, 5, 3);
    // Down count across zero
    run(4'd2, 4'd14, 1'b1, 1'b0, 4'd0, 5, -1, 0);
    // Loop 3..4 with gap 2, then abort during GAP
    run(4'd3, 4'd4, 1'b0, 1'b1, 4'd2, 10, -1, 0);

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_valid", 32'(bus.out_valid), 32'd0);
    check("sa_busy", 32'(bus.busy), 32'd0);
    tick();
    check("sa_valid2", 32'(bus.out_valid), 32'd0);

    // Single-code ranges
    run(4'd9, 4'd9, 1'b0, 1'b0, 4'd1, 1, -1, 0);
    run(4'd7, 4'd7, 1'b1, 1'b1, 4'd1, 4, -1, 0);

    // Randomized ranges, directions, gaps and loop mode
    for (int r = 0; r < 8; r++) begin
      f = 4'($urandom);
      l = 4'($urandom);
      d = 1'($urandom_range(0, 1));
      if (r % 3 == 2)
        run(f, l, d, 1'b1, 4'($urandom_range(0, 3)), 2 * seq_len(f, l, d) + 1, -1, 0);
      else
        run(f, l, d, 1'b0, 4'($urandom_range(0, 3)), seq_len(f, l, d), -1, 0);
    end

    // Asynchronous reset mid-run at bin 6
    bus.cfg_first = 4'd0;
    bus.cfg_last  = 4'd15;
    bus.cfg_dir   = 1'b0;
    bus.cfg_loop  = 1'b0;
    bus.cfg_div   = 4'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) transfer(4'(i), 0, 0, 1'b0, 1'b0);
    check("pre_rst_bin", 32'(bus.out_bin), 32'd6);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_bin", 32'(bus.out_bin), 32'd0);
    check("arst_gray", 32'(bus.out_gray), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_wrap", 32'(bus.wrap), 32'd0);
    check("arst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_valid", 32'(bus.out_valid), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd0);
    tick();
    check("rel_valid2", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
